// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache request port between a data port (0) and a fetch/loader port (1).
// Each transaction is sequenced IDLE -> ISSUE -> WAIT -> RESP, and a watchdog bounds the time spent in WAIT.
module cache_arbiter #(
  parameter logic [15:0] WAIT_LIMIT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [26:0] addr0,
  input  logic [26:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        write0,
  input  logic        write1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        timeout_flag,
  output logic [26:0] c_addr,
  output logic [31:0] c_write_data,
  output logic        c_write,
  output logic        c_enable,
  input  logic [31:0] c_read_data,
  input  logic        c_available
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d, last_q, last_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [26:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d, fin_data;
  logic        write_q, write_d, enable_q, enable_d, busy_q, busy_d, timeout_q, timeout_d;
  logic        done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
  logic        pick, timed_out;

  // Next-state, operand latch and response logic for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    timeout_d = timeout_q;
    enable_d  = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    cnt_inc   = cnt_q + 16'd1;
    // With both ports requesting, the one not served last wins.
    pick      = (req0 && req1) ? ~last_q : req1;
    timed_out = (WAIT_LIMIT != 16'd0) && (cnt_inc == WAIT_LIMIT);
    fin_data  = c_available ? c_read_data : 32'd0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = ISSUE;
          enable_d = 1'b1;
          gnt_d    = pick;
          last_d   = pick;
          addr_d   = pick ? addr1 : addr0;
          wdata_d  = pick ? wdata1 : wdata0;
          write_d  = pick ? write1 : write0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 16'd0;
      end
      WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (c_available || timed_out) begin
          state_d   = RESP;
          done0_d   = ~gnt_q;
          done1_d   = gnt_q;
          err0_d    = ~c_available & ~gnt_q;
          err1_d    = ~c_available & gnt_q;
          timeout_d = timeout_q | ~c_available;
          if (!write_q && !gnt_q) begin
            rdata0_d = fin_data;
          end else begin
            rdata0_d = rdata0_q;
          end
          if (!write_q && gnt_q) begin
            rdata1_d = fin_data;
          end else begin
            rdata1_d = rdata1_q;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 16'd0;
      addr_q    <= 27'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      timeout_q <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      timeout_q <= timeout_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign c_addr       = addr_q;
  assign c_write_data = wdata_q;
  assign c_write      = write_q;
  assign c_enable     = enable_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign busy         = busy_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a behavioural cache answers c_enable, expected responses are queued
// by the stimulus and matched against done pulses by an independent monitor.
module tb_cache_arbiter;

  logic        clk, rst;
  logic        req0, req1, write0, write1;
  logic [26:0] addr0, addr1, c_addr;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, c_write_data, c_read_data;
  logic        done0, done1, err0, err1, busy, timeout_flag, c_write, c_enable, c_available;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [26:0]];
  logic        stall, stale_req;
  int          miss_lat;

  cache_arbiter #(.WAIT_LIMIT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .write0(write0), .write1(write1),
    .rdata0(rdata0), .rdata1(rdata1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .busy(busy), .timeout_flag(timeout_flag),
    .c_addr(c_addr), .c_write_data(c_write_data),
    .c_write(c_write), .c_enable(c_enable),
    .c_read_data(c_read_data), .c_available(c_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural cache: answers miss_lat cycles after the hit slot, never while stalled.
  initial begin
    bit          pend;
    int          pend_cnt;
    logic [26:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_write;
    pend = 1'b0; pend_cnt = 0; p_addr = 27'd0; p_wdata = 32'd0; p_write = 1'b0;
    c_available = 1'b0;
    c_read_data = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      c_available = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (!stall && pend_cnt == 0) begin
          c_available = 1'b1;
          if (p_write) mem[p_addr] = p_wdata;
          else c_read_data = mem.exists(p_addr) ? mem[p_addr] : 32'd0;
          pend = 1'b0;
        end else if (!stall) begin
          pend_cnt--;
        end
      end else if (stale_req) begin
        c_available = 1'b1;
        c_read_data = 32'hBAD0_BAD0;
        stale_req = 1'b0;
      end
      if (c_enable && !rst) begin
        pend = 1'b1; pend_cnt = miss_lat;
        p_addr = c_addr; p_wdata = c_write_data; p_write = c_write;
      end
    end
  end

  // Monitor: every done pulse must match the oldest queued expectation; c_enable must be one cycle wide.
  initial begin
    sb_t  e;
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (c_enable) chk("enable_width", {31'd0, en_prev}, 32'd0);
      en_prev = c_enable;
      if (done0 && done1) begin
        chk("done_both", {30'd0, done1, done0}, 32'd1);
      end else if (done0 || done1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_port", {31'd0, done1}, {31'd0, e.port});
          chk("rdata", done1 ? rdata1 : rdata0, e.rdata);
          chk("err", {30'd0, err1, err0}, e.port ? {30'd0, e.err, 1'b0} : {30'd0, 1'b0, e.err});
        end
      end
    end
  end

  task automatic expect_resp(input logic port, input logic [31:0] rd, input logic er);
    sb_t e;
    e.port = port; e.rdata = rd; e.err = er;
    sb_q.push_back(e);
  endtask

  // One complete transaction from IDLE; returns with the DUT back in IDLE.
  task automatic run_txn(input logic port, input logic [26:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int cyc, avail_cyc;
    bit got;
    expect_resp(port, exp_rd, exp_err);
    if (port) begin
      req1 = 1'b1; addr1 = addr; write1 = wr; wdata1 = wd;
    end else begin
      req0 = 1'b1; addr0 = addr; write0 = wr; wdata0 = wd;
    end
    cyc = 0; avail_cyc = -10; got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        chk("c_addr_stable", {5'd0, c_addr}, {5'd0, addr});
        chk("c_write_stable", {31'd0, c_write}, {31'd0, wr});
        chk("c_wdata_stable", c_write_data, wd);
        if (c_available) avail_cyc = cyc;
      end
      got = port ? done1 : done0;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", cyc, exp_lat);
    if (!exp_err) chk("done_after_avail", cyc, avail_cyc + 1);
    @(negedge clk);
  endtask

  initial begin
    int n, last_cyc, cyc;
    mem[27'h10] = 32'hDEAD_BEEF;
    mem[27'h20] = 32'hA0A0_0001;
    mem[27'h24] = 32'hB0B0_0002;
    stall = 1'b0; stale_req = 1'b0; miss_lat = 0;
    rst = 1'b1;
    req0 = 1'b1; addr0 = 27'h20; write0 = 1'b0; wdata0 = 32'd0;
    req1 = 1'b1; addr1 = 27'h24; write1 = 1'b0; wdata1 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_enable", {31'd0, c_enable}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_flag}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_c_addr", {5'd0, c_addr}, 32'd0);

    // Contention from reset: port 0 first, then strict alternation, 4 cycles apart.
    expect_resp(1'b0, 32'hA0A0_0001, 1'b0);
    expect_resp(1'b1, 32'hB0B0_0002, 1'b0);
    expect_resp(1'b0, 32'hA0A0_0001, 1'b0);
    expect_resp(1'b1, 32'hB0B0_0002, 1'b0);
    rst = 1'b0;
    n = 0; last_cyc = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done0 || done1) begin
        if (n == 0) chk("rr_first_latency", cyc, 3);
        else chk("rr_spacing", cyc - last_cyc, 4);
        last_cyc = cyc;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", n, 4);
    @(negedge clk);

    run_txn(1'b0, 27'h10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);
    miss_lat = 5;
    run_txn(1'b1, 27'h4010, 1'b1, 32'h1234_5678, 32'hB0B0_0002, 1'b0, 8);
    miss_lat = 0;
    run_txn(1'b0, 27'h4010, 1'b0, 32'd0, 32'h1234_5678, 1'b0, 3);

    // Stale available in IDLE must not complete anything.
    stale_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stale_busy", {31'd0, busy}, 32'd0);
    miss_lat = 3;
    run_txn(1'b0, 27'h10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 6);
    miss_lat = 0;

    // Reset two cycles after ISSUE drops the transaction without a done.
    stall = 1'b1;
    req0 = 1'b1; addr0 = 27'h10; write0 = 1'b0; wdata0 = 32'd0;
    cyc = 0;
    while (!c_enable && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("issue_seen", {31'd0, c_enable}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_enable", {31'd0, c_enable}, 32'd0);
    chk("midrst_done", {30'd0, done1, done0}, 32'd0);
    chk("midrst_rdata0", rdata0, 32'd0);
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 27'h10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);

    // Timeout with WAIT_LIMIT 8: done+err 9 cycles after ISSUE, rdata cleared, sticky flag.
    stall = 1'b1;
    run_txn(1'b0, 27'h30, 1'b0, 32'd0, 32'd0, 1'b1, 10);
    chk("timeout_flag", {31'd0, timeout_flag}, 32'd1);
    repeat (100) @(negedge clk);
    chk("timeout_sticky", {31'd0, timeout_flag}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

- Two-port round-robin arbiter that shares the single `cache` request port between two requesters: port 0 is core data, port 1 is instruction fetch or loader.
- Sequences every cache transaction:
  - pulses `enable` for exactly one cycle;
  - holds address, data and write stable until `available`;
  - returns read data and a one-cycle done pulse to the granted requester.
- Sits between the requesters and `cache`.
- Adds a wait-limit watchdog so a hung memory path is reported rather than silently stalling.

## Interface
- `WAIT_LIMIT`, default 16'd1023: maximum cycles in WAIT before timeout. 0 disables the watchdog.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request; held high with operands stable until the matching `done`.
- `addr0`, `addr1`  in  27  byte address.
- `wdata0`, `wdata1`  in  32  write data.
- `write0`, `write1`  in  1  1 = write, 0 = read.
- `rdata0`, `rdata1`  out  32  read data; valid from the `done` cycle, held until that port's next read completes.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  qualifies `done`: the transaction timed out.
- `busy`  out  1  high in every state except IDLE.
- `timeout_flag`  out  1  sticky; set on any timeout, cleared only by `rst`.
- `c_addr`  out  27  to cache `addr`.
- `c_write_data`  out  32  to cache `write_data`.
- `c_write`  out  1  to cache `write`.
- `c_enable`  out  1  to cache `enable`.
- `c_read_data`  in  32  from cache `read_data`.
- `c_available`  in  1  from cache `available`.

## Operation
- Four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither request is high, stay.
  - If exactly one is high, grant it.
  - If both are high, grant the port that is not `last`.
  - On grant: latch the operands into `c_addr`, `c_write_data` and `c_write`; set `gnt`, set `last := gnt`, go to ISSUE.
- ISSUE:
  - `c_enable` = 1 for this cycle only.
  - Go to WAIT and clear the wait counter.
- WAIT:
  - `c_enable` = 0; the counter increments each cycle.
  - On `c_available` = 1:
    - capture `c_read_data` into `rdata[gnt]` (reads only; writes leave `rdata` unchanged);
    - go to RESP with `err` = 0.
  - Else, if `WAIT_LIMIT` != 0 and the counter reaches `WAIT_LIMIT`: go to RESP with `err` = 1, `rdata[gnt]` := 0 for reads, and `timeout_flag` := 1.
- RESP:
  - `done[gnt]` = 1 and `err[gnt]` = the captured err bit; then return to IDLE.
- `c_addr`, `c_write_data` and `c_write` stay constant from ISSUE through RESP. The cache re-reads `write` during miss completion, so these must not change.
- `c_available` is ignored outside WAIT, so a stale pulse never completes a transaction.
- A request that drops before its `done` is a protocol violation. The latched operands still complete; `done` is still pulsed.
- `req` still high in the cycle after `done` is a new request. It competes in IDLE under round-robin.

## Timing
- All outputs are registered.
- Reset values:
  - `c_enable`, `c_write`, `done*`, `err*`, `busy`, `timeout_flag`: 0.
  - `c_addr`, `c_write_data`, `rdata*`: 0.
  - `last` = 1, so port 0 wins the first contention; the counter is 0.
- Cache hit:
  - `req` sampled in IDLE at edge T.
  - `c_enable` high in cycle T+1.
  - `c_available` in T+2.
  - `done` in T+3.
  - Next grant possible at edge T+4. This gives 4 cycles/transaction for back-to-back hits.
- Miss: `done` follows `c_available` by exactly 1 cycle, whatever the miss length.
- Timeout: `done` with `err` arrives `WAIT_LIMIT`+1 cycles after the ISSUE cycle.
- `rst` mid-transaction:
  - Next cycle is IDLE; the in-flight transaction is dropped with no `done`.
  - The cache is not reset by this block. The integration asserts `rst` only while the cache is idle, or re-initialises it alongside.
- Simultaneous `req0` and `req1` arriving in the RESP cycle: arbitration happens in the following IDLE cycle, never in RESP.

## Test plan
- **Single read hit.** Preload line 0x0000010 with word 0xDEADBEEF; `req0` read addr 0x0000010. Expect:
  - `c_enable` high exactly 1 cycle;
  - `done0` 3 cycles after `req`, `rdata0` = 0xDEADBEEF, `err0` = 0, `done1` = 0.
- **Write miss with dirty victim.** `req1` write 0x0004010 data 0x12345678 while the cache line is dirty. Expect:
  - `c_write` and `c_addr` constant until `c_available`;
  - `done1` 1 cycle after `available`;
  - a following port-0 read of 0x0004010 returns 0x12345678.
- **Contention.** `req0` and `req1` held high continuously from reset, both reading. Grants alternate 0, 1, 0, 1, with `done` pulses spaced 4 cycles apart on hits.
- **Timeout.** `WAIT_LIMIT` = 8 and `c_available` tied low. Expect:
  - `done0` = 1 with `err0` = 1, 9 cycles after ISSUE, `rdata0` = 0, `timeout_flag` = 1;
  - `timeout_flag` still 1 after 100 idle cycles.
- **Stale available.** Pulse `c_available` while in IDLE, then start a read miss. The transaction completes only on the true `available`; no early `done`.
- **Reset mid-WAIT.** Assert `rst` 2 cycles after ISSUE. Next cycle:
  - `busy` = 0, `c_enable` = 0, no `done`;
  - a subsequent `req0` hit completes normally with 3-cycle latency.
